// File: rtl/ram_scan_pkg.sv
// Shared types and default widths for the RAM scan reader.
package ram_scan_pkg;

   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned DATA_W_DEF = 4;

   typedef enum logic [1:0] {
      S_ISSUE = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2
   } scan_state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick every TICK_DIV clocks while en is high.
module tick_gen #(
   parameter int unsigned TICK_DIV = 50_000_000
) (
   input  logic CLOCK_50,
   input  logic reset,
   input  logic en,
   output logic tick
);

   localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             at_max_c;

   // Count only while enabled; dropping en restarts the period from zero.
   always_comb begin
      cnt_d    = cnt_q;
      at_max_c = (cnt_q == CNT_MAX);
      if (!en) begin
         cnt_d = '0;
      end else if (at_max_c) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en && at_max_c;

endmodule

// File: rtl/ram_scan_reader.sv
// Read-side walker for the display RAM: issues each address in turn, captures the
// returned word, and advances on a divided tick (run=1) or a step press (run=0).
module ram_scan_reader
   import ram_scan_pkg::*;
#(
   parameter int unsigned ADDR_W   = ADDR_W_DEF,
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter int unsigned RD_LAT   = 1
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              run,
   input  logic              step,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] ram_q,
   output logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              valid,
   output logic              wrapped
);

   localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RD_LAT - 1);

   scan_state_t       state_q;
   scan_state_t       state_d;
   logic [LAT_W-1:0]  lat_q;
   logic [LAT_W-1:0]  lat_d;
   logic [ADDR_W-1:0] rd_addr_q;
   logic [ADDR_W-1:0] rd_addr_d;
   logic [ADDR_W-1:0] disp_addr_q;
   logic [ADDR_W-1:0] disp_addr_d;
   logic [DATA_W-1:0] disp_data_q;
   logic [DATA_W-1:0] disp_data_d;
   logic              valid_q;
   logic              valid_d;
   logic              wrapped_q;
   logic              wrapped_d;
   logic              step_q;
   logic              step_d;
   logic              tick;
   logic              step_rise_c;
   logic              advance_c;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .en       (run),
      .tick     (tick)
   );

   // Next-state and capture logic; events arriving outside S_HOLD are simply dropped.
   always_comb begin
      state_d     = state_q;
      lat_d       = lat_q;
      rd_addr_d   = rd_addr_q;
      disp_addr_d = disp_addr_q;
      disp_data_d = disp_data_q;
      valid_d     = 1'b0;
      wrapped_d   = 1'b0;
      step_d      = step;
      step_rise_c = step & ~step_q;
      advance_c   = run ? tick : step_rise_c;

      case (state_q)
         S_ISSUE: begin
            lat_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (lat_q == LAT_LAST) begin
               disp_data_d = ram_q;
               disp_addr_d = rd_addr_q;
               valid_d     = 1'b1;
               state_d     = S_HOLD;
            end else begin
               lat_d = lat_q + LAT_W'(1);
            end
         end
         S_HOLD: begin
            // Keep tracking the RAM so writes to the shown word reach the display.
            disp_data_d = ram_q;
            if (advance_c) begin
               rd_addr_d = rd_addr_q + ADDR_W'(1);
               wrapped_d = (rd_addr_q == '1);
               state_d   = S_ISSUE;
            end
         end
         default: begin
            state_d = S_ISSUE;
         end
      endcase
   end

   // step_q resets high so a button held through reset does not count as a press.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q     <= S_ISSUE;
         lat_q       <= '0;
         rd_addr_q   <= '0;
         disp_addr_q <= '0;
         disp_data_q <= '0;
         valid_q     <= 1'b0;
         wrapped_q   <= 1'b0;
         step_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         rd_addr_q   <= rd_addr_d;
         disp_addr_q <= disp_addr_d;
         disp_data_q <= disp_data_d;
         valid_q     <= valid_d;
         wrapped_q   <= wrapped_d;
         step_q      <= step_d;
      end
   end

   assign rd_addr   = rd_addr_q;
   assign disp_addr = disp_addr_q;
   assign disp_data = disp_data_q;
   assign valid     = valid_q;
   assign wrapped   = wrapped_q;

endmodule
